// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the 18-key piano voice allocator: key count, key
// index width, the per-key DDS tuning-word table and the scan FSM states.
// -----------------------------------------------------------------------------
package piano_pkg;

    localparam int NUM_KEYS = 18;
    localparam int IDX_W    = 5;

    // DDS tuning word M for each key, lowest key first (32-bit accumulator).
    localparam logic [31:0] TW_TABLE [0:NUM_KEYS-1] = '{
        32'd93664,  32'd99230,  32'd105130, 32'd111385, 32'd118008, 32'd125024,
        32'd132456, 32'd140336, 32'd148677, 32'd157520, 32'd166885, 32'd176809,
        32'd187324, 32'd198464, 32'd210264, 32'd222766, 32'd236012, 32'd250049
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ALLOC,
        FREE
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low keys, samples them once per debounce period
// and only accepts a new level for a key when two consecutive samples agree.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   key   in   raw keys, 0 = pressed, asynchronous
//   deb   out  debounced keys, 1 = pressed
//   tick  out  one-cycle strobe on the cycle the period counter wraps
// -----------------------------------------------------------------------------
module key_debounce
    import piano_pkg::*;
#(
    parameter int DEB_CYCLES = 240000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] deb,
    output logic                tick
);

    localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] samp_q, samp_d;
    logic [NUM_KEYS-1:0] deb_q, deb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] agree;

    assign tick    = (cnt_q == CNT_MAX);
    assign pressed = ~sync2_q;
    assign agree   = ~(pressed ^ samp_q);
    assign deb     = deb_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        sync1_d = key;
        sync2_d = sync1_q;
        samp_d  = samp_q;
        deb_d   = deb_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
            samp_d = pressed;
            // A key only changes when this sample repeats the previous one.
            deb_d  = (agree & pressed) | (~agree & deb_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Released level, so the synchroniser never reports phantom presses out of reset.
            sync1_q <= '1;
            sync2_q <= '1;
            samp_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/piano_voice_alloc.sv
// -----------------------------------------------------------------------------
// piano_voice_alloc
// Scans the debounced keys after every debounce tick and maps press/release
// events onto NUM_VOICES harmonic generator slots. A press takes the lowest
// free slot, or steals the oldest one when all are sounding; a release
// silences the slot(s) still owned by that key.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   key        in   raw keys, 0 = pressed, asynchronous
//   voice_en   out  per-slot enable, 1 = sounding
//   voice_tw   out  per-slot tuning word, slot v at [v*TW_W +: TW_W]
//   voice_key  out  per-slot owning key index, slot v at [v*5 +: 5]
//   busy       out  high while the scan FSM is not idle
// -----------------------------------------------------------------------------
module piano_voice_alloc
    import piano_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DEB_CYCLES = 240000,
    parameter int TW_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_KEYS-1:0]        key,
    output logic [NUM_VOICES-1:0]      voice_en,
    output logic [NUM_VOICES*TW_W-1:0] voice_tw,
    output logic [NUM_VOICES*IDX_W-1:0] voice_key,
    output logic                       busy
);

    localparam int               AGE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0] deb;
    logic                tick;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_KEYS-1:0] served_q, served_d;
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [TW_W-1:0]     tw_q   [NUM_VOICES];
    logic [TW_W-1:0]     tw_d   [NUM_VOICES];
    logic [IDX_W-1:0]    vkey_q [NUM_VOICES];
    logic [IDX_W-1:0]    vkey_d [NUM_VOICES];
    logic [AGE_W-1:0]    age_q  [NUM_VOICES];
    logic [AGE_W-1:0]    age_d  [NUM_VOICES];

    logic             press_ev, release_ev, last_key, any_free;
    logic [AGE_W-1:0] free_slot, old_slot, tgt_slot, old_age;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .key (key),
        .deb (deb),
        .tick(tick)
    );

    assign press_ev   = deb[idx_q] & ~served_q[idx_q];
    assign release_ev = ~deb[idx_q] & served_q[idx_q];
    assign last_key   = (idx_q == IDX_LAST);
    assign tgt_slot   = any_free ? free_slot : old_slot;

    // Slot choice for an allocation: lowest free slot, else the oldest
    // (strict compare keeps the lowest index on equal ages).
    always_comb begin
        any_free  = 1'b0;
        free_slot = '0;
        old_slot  = '0;
        old_age   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!en_q[v]) begin
                any_free  = 1'b1;
                free_slot = AGE_W'(v);
            end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_age  = age_q[v];
                old_slot = AGE_W'(v);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        served_d = served_q;
        en_d     = en_q;
        tw_d     = tw_q;
        vkey_d   = vkey_q;
        age_d    = age_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (press_ev) begin
                    state_d = ALLOC;
                end else if (release_ev) begin
                    state_d = FREE;
                end else if (last_key) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ALLOC: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (AGE_W'(v) == tgt_slot) begin
                        en_d[v]   = 1'b1;
                        tw_d[v]   = TW_W'(TW_TABLE[idx_q]);
                        vkey_d[v] = idx_q;
                        age_d[v]  = '0;
                    end else if (en_q[v] && age_q[v] != AGE_MAX) begin
                        age_d[v] = age_q[v] + 1'b1;
                    end
                end
                // A stolen key keeps its served bit; its release later finds no slot.
                served_d[idx_q] = 1'b1;
                state_d         = last_key ? IDLE : SCAN;
                idx_d           = last_key ? idx_q : idx_q + 1'b1;
            end
            FREE: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (en_q[v] && vkey_q[v] == idx_q) begin
                        en_d[v] = 1'b0;
                    end
                end
                served_d[idx_q] = 1'b0;
                state_d         = last_key ? IDLE : SCAN;
                idx_d           = last_key ? idx_q : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            served_q <= '0;
            en_q     <= '0;
            // NOTE: the slot arrays are a few flops whose values show on the ports, so they are reset with the control state.
            for (int v = 0; v < NUM_VOICES; v++) begin
                tw_q[v]   <= '0;
                vkey_q[v] <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            served_q <= served_d;
            en_q     <= en_d;
            tw_q     <= tw_d;
            vkey_q   <= vkey_d;
            age_q    <= age_d;
        end
    end

    assign voice_en = en_q;
    assign busy     = (state_q != IDLE);

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_tw[g*TW_W +: TW_W]    = tw_q[g];
        assign voice_key[g*IDX_W +: IDX_W] = vkey_q[g];
    end

endmodule
